// File: rtl/crypt_key_fifo_if.sv
// Bus bundle for crypt_key_fifo: write side, read side and status.
// The FIFO takes the slave view; whoever drives requests takes the master view.
interface crypt_key_fifo_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              we;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] key_in;
    logic              wr_ready;
    logic              re;
    logic              rd_ready;
    logic [DATA_W-1:0] enc_out;
    logic              enc_valid;
    logic [DATA_W-1:0] dec_out;
    logic              dec_valid;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              wr_drop;
    logic              rd_drop;

    modport master (
        output we, data_in, key_in, re,
        input  wr_ready, rd_ready, enc_out, enc_valid, dec_out, dec_valid,
               count, full, empty, wr_drop, rd_drop
    );

    modport slave (
        input  we, data_in, key_in, re,
        output wr_ready, rd_ready, enc_out, enc_valid, dec_out, dec_valid,
               count, full, empty, wr_drop, rd_drop
    );
endinterface

// File: rtl/crypt_key_fifo.sv
// Encrypt-on-write / decrypt-on-read FIFO. Each word is encrypted with its own
// key by an iterative round engine (one round per clock) and stored together
// with that key; a read pops the head entry and runs the inverse rounds.
// The write and read engines are independent and may run at the same time.
module crypt_key_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int ROUNDS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    crypt_key_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS - 1);

    typedef enum logic { E_IDLE, E_RUN } encState_t;
    typedef enum logic { D_IDLE, D_RUN } decState_t;

    // Round key: key rotated left by 8*r bits (mod width), xored with r.
    function automatic logic [DATA_W-1:0] roundKey(input logic [DATA_W-1:0] k,
                                                   input logic [RW-1:0]     r);
        int amt;
        amt = (8 * int'(r)) % DATA_W;
        return ((k << amt) | (k >> (DATA_W - amt))) ^ DATA_W'(r);
    endfunction

    function automatic logic [DATA_W-1:0] encRound(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] k,
                                                   input logic [RW-1:0]     r);
        logic [DATA_W-1:0] t;
        t = x ^ roundKey(k, r);
        return {t[DATA_W-2:0], t[DATA_W-1]};
    endfunction

    function automatic logic [DATA_W-1:0] decRound(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] k,
                                                   input logic [RW-1:0]     r);
        return {x[0], x[DATA_W-1:1]} ^ roundKey(k, r);
    endfunction

    encState_t         encState_q, encState_d;
    logic [DATA_W-1:0] encX_q, encX_d, encKey_q, encKey_d;
    logic [RW-1:0]     encRnd_q, encRnd_d;
    logic [DATA_W-1:0] encOut_q, encOut_d;
    logic              encValid_q, encValid_d;

    decState_t         decState_q, decState_d;
    logic [DATA_W-1:0] decX_q, decX_d, decKey_q, decKey_d;
    logic [RW-1:0]     decRnd_q, decRnd_d;
    logic [DATA_W-1:0] decOut_q, decOut_d;
    logic              decValid_q, decValid_d;

    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wrDrop_q, wrDrop_d, rdDrop_q, rdDrop_d;
    logic              push, pop, wrReady, rdReady;

    // Each entry holds {ciphertext, key}.
    logic [2*DATA_W-1:0] mem [DEPTH];

    assign wrReady       = (encState_q == E_IDLE) && (count_q != FULL_CNT);
    assign rdReady       = (decState_q == D_IDLE) && (count_q != '0);
    assign bus.wr_ready  = wrReady;
    assign bus.rd_ready  = rdReady;
    assign bus.count     = count_q;
    assign bus.full      = (count_q == FULL_CNT);
    assign bus.empty     = (count_q == '0);
    assign bus.enc_out   = encOut_q;
    assign bus.enc_valid = encValid_q;
    assign bus.dec_out   = decOut_q;
    assign bus.dec_valid = decValid_q;
    assign bus.wr_drop   = wrDrop_q;
    assign bus.rd_drop   = rdDrop_q;

    // Next-state logic for both engines, pointers, occupancy and drop flags.
    always_comb begin
        encState_d = encState_q;
        encX_d     = encX_q;
        encKey_d   = encKey_q;
        encRnd_d   = encRnd_q;
        encOut_d   = encOut_q;
        encValid_d = 1'b0;
        decState_d = decState_q;
        decX_d     = decX_q;
        decKey_d   = decKey_q;
        decRnd_d   = decRnd_q;
        decOut_d   = decOut_q;
        decValid_d = 1'b0;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        push       = 1'b0;
        pop        = 1'b0;
        wrDrop_d   = bus.we && !wrReady;
        rdDrop_d   = bus.re && !rdReady;

        case (encState_q)
            E_IDLE: begin
                if (bus.we && wrReady) begin
                    encX_d     = bus.data_in;
                    encKey_d   = bus.key_in;
                    encRnd_d   = '0;
                    encState_d = E_RUN;
                end
            end
            E_RUN: begin
                encX_d   = encRound(encX_q, encKey_q, encRnd_q);
                encRnd_d = encRnd_q + 1'b1;
                if (encRnd_q == LAST_RND) begin
                    push       = 1'b1;
                    encOut_d   = encX_d;
                    encValid_d = 1'b1;
                    encRnd_d   = '0;
                    wptr_d     = wptr_q + 1'b1;
                    encState_d = E_IDLE;
                end
            end
            default: encState_d = E_IDLE;
        endcase

        case (decState_q)
            D_IDLE: begin
                if (bus.re && rdReady) begin
                    {decX_d, decKey_d} = mem[rptr_q];
                    pop        = 1'b1;
                    rptr_d     = rptr_q + 1'b1;
                    decRnd_d   = LAST_RND;
                    decState_d = D_RUN;
                end
            end
            D_RUN: begin
                decX_d   = decRound(decX_q, decKey_q, decRnd_q);
                decRnd_d = decRnd_q - 1'b1;
                if (decRnd_q == '0) begin
                    decOut_d   = decX_d;
                    decValid_d = 1'b1;
                    decRnd_d   = '0;
                    decState_d = D_IDLE;
                end
            end
            default: decState_d = D_IDLE;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset throws away in-flight words and all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            encState_q <= E_IDLE;
            encX_q     <= '0;
            encKey_q   <= '0;
            encRnd_q   <= '0;
            encOut_q   <= '0;
            encValid_q <= 1'b0;
            decState_q <= D_IDLE;
            decX_q     <= '0;
            decKey_q   <= '0;
            decRnd_q   <= '0;
            decOut_q   <= '0;
            decValid_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            wrDrop_q   <= 1'b0;
            rdDrop_q   <= 1'b0;
        end else begin
            encState_q <= encState_d;
            encX_q     <= encX_d;
            encKey_q   <= encKey_d;
            encRnd_q   <= encRnd_d;
            encOut_q   <= encOut_d;
            encValid_q <= encValid_d;
            decState_q <= decState_d;
            decX_q     <= decX_d;
            decKey_q   <= decKey_d;
            decRnd_q   <= decRnd_d;
            decOut_q   <= decOut_d;
            decValid_q <= decValid_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            wrDrop_q   <= wrDrop_d;
            rdDrop_q   <= rdDrop_d;
        end
    end

    // Storage array; stale contents are harmless because count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= {encX_d, encKey_q};
        end
    end
endmodule
